// File: rtl/mdu_iter_pkg.sv
// Shared encodings and default sizing for the iterative multiply/divide unit.
// The stall unit and decode logic import these so they agree with mdu_iter.
package mdu_iter_pkg;

  localparam int MDU_WIDTH_DEF       = 32;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_EXTRA_DEF   = 1;

  // Operation select; 6 and 7 are reserved and act as no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Execute-stage port bundle between the DE pipeline register and the MDU.
// Handshake: start is a request that the MDU accepts only on an edge where
// busy=0; while busy=1 start is ignored and hi/lo hold their old values.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, md_op, a, b,
    input  busy, hi, lo, div_zero
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, hi, lo, div_zero
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           take;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // A borrow out of the extra top bit means the divisor did not fit.
    take    = ~diff[WIDTH];
    rem_out = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], take};
  end
endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with HI/LO: fixed-latency multiply, one-bit-per-cycle
// restoring divide with an optional sign fix-up phase, and mthi/mtlo moves.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH_DEF,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_EXTRA   = MDU_DIV_EXTRA_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_if.slave       md,
  output mdu_state_e dbg_state
);
  localparam int CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIX_LOAD = (DIV_EXTRA > 0) ? CW'(DIV_EXTRA - 1) : '0;

  mdu_state_e       state;
  logic [CW-1:0]    counter;
  logic             busy;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mul_signed;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quo_neg;
  logic             rem_neg;

  logic             is_signed_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] quo_src;
  logic [WIDTH-1:0] hi_div;
  logic [WIDTH-1:0] lo_div;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_comb begin
    is_signed_div = (md.md_op == MD_DIV);
    a_neg = is_signed_div & md.a[WIDTH-1];
    b_neg = is_signed_div & md.b[WIDTH-1];
    abs_a = a_neg ? -md.a : md.a;
    abs_b = b_neg ? -md.b : md.b;
    // Sign-extend both operands so one unsigned multiplier serves mult and multu.
    product = {{WIDTH{mul_signed & op_a[WIDTH-1]}}, op_a}
            * {{WIDTH{mul_signed & op_b[WIDTH-1]}}, op_b};
    // Without a fix-up phase the result is taken straight from the last step.
    rem_src = (state == ST_DIV) ? rem_nxt : rem_q;
    quo_src = (state == ST_DIV) ? quo_nxt : quo_q;
    hi_div  = rem_neg ? -rem_src : rem_src;
    lo_div  = div_zero ? '1 : (quo_neg ? -quo_src : quo_src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      busy       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quo_neg    <= 1'b0;
      rem_neg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.start) begin
            div_zero <= 1'b0;
            case (md.md_op)
              MD_MTHI: hi <= md.a;
              MD_MTLO: lo <= md.a;
              MD_MULT, MD_MULTU: begin
                op_a       <= md.a;
                op_b       <= md.b;
                mul_signed <= (md.md_op == MD_MULT);
                counter    <= MUL_LOAD;
                busy       <= 1'b1;
                state      <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                rem_q    <= '0;
                quo_q    <= abs_a;
                dvs_q    <= abs_b;
                quo_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                div_zero <= (md.b == '0);
                counter  <= DIV_LOAD;
                busy     <= 1'b1;
                state    <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (counter == '0) begin
            {hi, lo} <= product;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (counter == '0) begin
            if (DIV_EXTRA == 0) begin
              hi    <= hi_div;
              lo    <= lo_div;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              counter <= FIX_LOAD;
              state   <= ST_FIX;
            end
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_FIX: begin
          if (counter == '0) begin
            hi    <= hi_div;
            lo    <= lo_div;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy     = busy;
  assign md.hi       = hi;
  assign md.lo       = lo;
  assign md.div_zero = div_zero;
  assign dbg_state   = state;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and random ops checked against a behavioural
// model through an expected-result queue.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W      = 32;
  localparam int MC     = 5;
  localparam int DE     = 1;
  localparam int DIV_CY = W + DE;

  logic       clk;
  logic       rst_n;
  mdu_state_e dbg_state;

  mdu_if #(.WIDTH(W)) md ();

  mdu_iter #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_EXTRA(DE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md        (md),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi = '0;
  logic [W-1:0]   cur_lo = '0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] h,
                                           input logic [W-1:0] l);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2, 3'd3: begin
        if (b == '0) return {a, {W{1'b1}}};
        q = (op == 3'd2) ? sa / sb : ua / ub;
        r = (op == 3'd2) ? sa % sb : ua % ub;
        return {r[W-1:0], q[W-1:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] op);
    if (op <= 3'd1) return MC;
    if (op <= 3'd3) return DIV_CY;
    return 0;
  endfunction

  // driver: pushes the expected result, launches, then counts busy cycles
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc);
    exp_q.push_back(model(op, a, b, cur_hi, cur_lo));
    {cur_hi, cur_lo} = exp_q[$];
    @(negedge clk);
    md.start = 1'b1; md.md_op = op; md.a = a; md.b = b;
    @(negedge clk);
    md.start = 1'b0; md.a = $urandom; md.b = $urandom;
    cyc = 0;
    while (md.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md.start = 1'b0; md.md_op = 3'd0; md.a = '0; md.b = '0;
    repeat (2) @(negedge clk);
    total++; if (md.hi !== '0) begin bad++; $display("FAIL reset_hi got=%h want=0", md.hi); end
    total++; if (md.lo !== '0) begin bad++; $display("FAIL reset_lo got=%h want=0", md.lo); end
    total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", md.busy); end
    total++; if (md.div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", md.div_zero); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_move();
    logic busy_seen = 1'b0;
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_MTHI; md.a = 32'h1234;
    @(negedge clk);
    busy_seen |= md.busy;
    md.md_op = MD_MTLO; md.a = 32'h5678;
    @(negedge clk);
    busy_seen |= md.busy;
    md.start = 1'b0;
    @(negedge clk);
    busy_seen |= md.busy;
    cur_hi = 32'h1234; cur_lo = 32'h5678;
    total++; if (md.hi !== 32'h1234) begin bad++; $display("FAIL move_hi got=%h want=1234", md.hi); end
    total++; if (md.lo !== 32'h5678) begin bad++; $display("FAIL move_lo got=%h want=5678", md.lo); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL move_busy got=%b want=0", busy_seen); end
  endtask

  task automatic test_reset_mid_divide();
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_DIVU; md.a = 32'd100; md.b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (md.hi !== '0) begin bad++; $display("FAIL rstdiv_hi got=%h want=0", md.hi); end
    total++; if (md.lo !== '0) begin bad++; $display("FAIL rstdiv_lo got=%h want=0", md.lo); end
    total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL rstdiv_busy got=%b want=0", md.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    cur_hi = '0; cur_lo = '0;
    repeat (40) @(negedge clk);
    total++; if ({md.hi, md.lo} !== 64'd0) begin bad++; $display("FAIL rstdiv_late got=%h want=0", {md.hi, md.lo}); end
    total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL rstdiv_late_busy got=%b want=0", md.busy); end
  endtask

  task automatic test_mult();
    int cyc;
    logic [2*W-1:0] e;
    do_op(MD_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    e = exp_q.pop_front();
    total++; if (cyc != MC) begin bad++; $display("FAIL mult_cycles got=%0d want=%0d", cyc, MC); end
    total++; if ({md.hi, md.lo} !== 64'hFFFFFFFF_FFFFFFFA) begin bad++; $display("FAIL mult_neg got=%h want=FFFFFFFFFFFFFFFA", {md.hi, md.lo}); end
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    e = exp_q.pop_front();
    total++; if (cyc != MC) begin bad++; $display("FAIL multu_cycles got=%0d want=%0d", cyc, MC); end
    total++; if ({md.hi, md.lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_max got=%h want=FFFFFFFE00000001", {md.hi, md.lo}); end
    for (int i = 0; i < 6; i++) begin
      do_op(3'(i % 2), $urandom, $urandom, cyc);
      e = exp_q.pop_front();
      total++; if ({md.hi, md.lo} !== e) begin bad++; $display("FAIL mult_rand got=%h want=%h", {md.hi, md.lo}, e); end
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [2*W-1:0] e;
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    e = exp_q.pop_front();
    total++; if (cyc != DIV_CY) begin bad++; $display("FAIL div_cycles got=%0d want=%0d", cyc, DIV_CY); end
    total++; if ({md.hi, md.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_neg got=%h want=FFFFFFFFFFFFFFFD", {md.hi, md.lo}); end
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    e = exp_q.pop_front();
    total++; if (cyc != DIV_CY) begin bad++; $display("FAIL divovf_cycles got=%0d want=%0d", cyc, DIV_CY); end
    total++; if ({md.hi, md.lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_ovf got=%h want=0000000080000000", {md.hi, md.lo}); end
    total++; if (md.div_zero !== 1'b0) begin bad++; $display("FAIL div_ovf_dz got=%b want=0", md.div_zero); end
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] b;
      b = (i < 4) ? $urandom : W'($urandom_range(1, 1000));
      do_op(3'(2 + (i % 2)), $urandom, b, cyc);
      e = exp_q.pop_front();
      total++; if ({md.hi, md.lo} !== e) begin bad++; $display("FAIL div_rand got=%h want=%h", {md.hi, md.lo}, e); end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [2*W-1:0] e;
    exp_q.push_back({32'd5, 32'hFFFFFFFF});
    cur_hi = 32'd5; cur_lo = 32'hFFFFFFFF;
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_DIVU; md.a = 32'd5; md.b = 32'd0;
    @(negedge clk);
    md.start = 1'b0;
    total++; if (md.div_zero !== 1'b1) begin bad++; $display("FAIL dz_launch got=%b want=1", md.div_zero); end
    cyc = 0;
    while (md.busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    e = exp_q.pop_front();
    total++; if (cyc != DIV_CY) begin bad++; $display("FAIL dz_cycles got=%0d want=%0d", cyc, DIV_CY); end
    total++; if ({md.hi, md.lo} !== e) begin bad++; $display("FAIL dz_result got=%h want=%h", {md.hi, md.lo}, e); end
    total++; if (md.div_zero !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", md.div_zero); end
    exp_q.push_back(model(MD_MULT, 32'd7, 32'd6, cur_hi, cur_lo));
    {cur_hi, cur_lo} = exp_q[$];
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_MULT; md.a = 32'd7; md.b = 32'd6;
    @(negedge clk);
    md.start = 1'b0;
    total++; if (md.div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", md.div_zero); end
    cyc = 0;
    while (md.busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    e = exp_q.pop_front();
    total++; if ({md.hi, md.lo} !== 64'd42) begin bad++; $display("FAIL dz_mult got=%h want=%h", {md.hi, md.lo}, 64'd42); end
  endtask

  task automatic test_busy_start();
    int cyc;
    logic [2*W-1:0] e;
    logic [2*W-1:0] held;
    logic held_ok = 1'b1;
    held = {cur_hi, cur_lo};
    exp_q.push_back(model(MD_DIV, 32'd1000, 32'hFFFFFFFD, cur_hi, cur_lo));
    {cur_hi, cur_lo} = exp_q[$];
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_DIV; md.a = 32'd1000; md.b = 32'hFFFFFFFD;
    @(negedge clk);
    md.start = 1'b0;
    cyc = 0;
    while (md.busy === 1'b1 && cyc < 200) begin
      cyc++;
      md.start = (cyc == 5 || cyc == 6 || cyc == 12);
      md.md_op = (cyc == 12) ? MD_MULT : MD_MTHI;
      md.a = 32'hDEAD_BEEF; md.b = 32'd9;
      if ({md.hi, md.lo} !== held) held_ok = 1'b0;
      @(negedge clk);
    end
    md.start = 1'b0;
    e = exp_q.pop_front();
    total++; if (cyc != DIV_CY) begin bad++; $display("FAIL busy_start_cycles got=%0d want=%0d", cyc, DIV_CY); end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL busy_hold got=%b want=1", held_ok); end
    total++; if ({md.hi, md.lo} !== e) begin bad++; $display("FAIL busy_start_result got=%h want=%h", {md.hi, md.lo}, e); end
    repeat (3) @(negedge clk);
    total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b want=0", md.busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [2:0] op;
    logic [2*W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      do_op(op, $urandom, W'($urandom_range(0, 3) == 0 ? 0 : $urandom), cyc);
      e = exp_q.pop_front();
      total++; if (cyc != exp_cycles(op)) begin bad++; $display("FAIL b2b_cycles op=%0d got=%0d want=%0d", op, cyc, exp_cycles(op)); end
      total++; if ({md.hi, md.lo} !== e) begin bad++; $display("FAIL b2b_result op=%0d got=%h want=%h", op, {md.hi, md.lo}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_reset_mid_divide();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_start();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
